sd_cmd_sequencer: RTL and testbench
===================================

# sd_cmd_sequencer

Command-level controller for the SD SPI link. It accepts a command index and argument from the top-level SD state machine in main.v and assembles the 48-bit frame, including CRC7. It then sequences the serial command sender through its start/finish handshake, hunts for and shifts in the R1 (or R3/R7) response from MISO, and reports the result with a four-phase req/done handshake.

## Interface
Parameters:
- maxWait, 64: maximum spiClock cycles allowed between send finish and the response start bit (N_CR limit).
- longBits, 32: extra response bits captured after R1 when respLong=1 (R3/R7 payload).

Ports:
- spiClock  input  1  SPI bit clock. All state updates on its negedge, the codebase convention.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- req  input  1  command request; four-phase with done.
- cmdIndex  input  6  SD command index; sampled on the accepting edge.
- cmdArg  input  32  command argument; sampled on the accepting edge.
- respLong  input  1  1 = capture R1 + longBits, 0 = R1 only; sampled on the accepting edge.
- sendStart  output  1  start to the serial sender; held high until sendFinish is seen.
- sendCmd  output  48  frame to the sender; stable while sendStart=1.
- sendFinish  input  1  finish from the serial sender.
- bitin  input  1  MISO, sampled on negedge.
- busy  output  1  high from accept until done is asserted.
- done  output  1  result valid; held until req falls.
- timeout  output  1  valid with done; 1 = no start bit within maxWait.
- respR1  output  8  R1 byte, MSB first as received.
- respData  output  longBits  extra bits; 0 when respLong=0.

## Operation
- Frame layout: [47]=0, [46]=1, [45:40]=cmdIndex, [39:8]=cmdArg, [7:1]=CRC7, [0]=1.
- CRC7: polynomial x^7+x^3+1, init 0, computed serially over frame bits 47..8, MSB first, one bit per cycle.
- States:
  - IDLE: req=1 latches the inputs and goes to CRC.
  - CRC: 40 cycles, then goes to SEND.
  - SEND: sendStart=1 until sendFinish=1 is sampled, then sendStart drops and the block goes to WAIT.
  - WAIT: counts cycles. bitin=0 counts as the R1 MSB and goes to RECV. Counter reaching maxWait goes to DONE with timeout=1.
  - RECV: shifts in the remaining 7 R1 bits, plus longBits if respLong, then goes to DONE.
  - DONE: done=1 until req=0, then goes to IDLE.
- Handshake rules:
  - req falling before DONE is ignored; the operation completes, and done rises then drops on the next edge because req is already low.
  - A new request is accepted only in IDLE; req held high across DONE→IDLE starts nothing until req has been low for at least one edge.
- Any reset, including one mid-frame: state IDLE, all outputs 0, sendCmd=0, counters cleared. The sender sees start=0 and aborts per its own rules.

## Timing
- Reset values: sendStart=0, busy=0, done=0, timeout=0, respR1=0, respData=0, sendCmd=0.
- Accept edge → sendStart high: 41 negedges (1 latch + 40 CRC).
- sendFinish sampled high → sendStart low on the same edge.
- WAIT begins on the edge after sendStart drops. The counter counts from 1, so a start bit at count ≤ maxWait is accepted, and timeout occurs on edge maxWait+1 if none is seen.
- A start bit on the same edge the counter hits its limit counts as a response, not a timeout.
- Response bits: one per negedge; done rises on the edge after the last bit.
- respR1/respData/timeout update only on the edge entering DONE and hold until the next accept.

## Structure
- Shared package sd_pkg:
  - state encoding
  - frame field offsets (START=47, TX=46, IDX 45:40, ARG 39:8, CRC 7:1, END=0)
  - CRC7 polynomial constant 7'h09
  - command index constants CMD0, CMD8, CMD55, ACMD41, CMD58.
- One sub-module: crc7_serial, with clear, enable, data bit in and 7-bit crc out.

## Test plan
- CMD0, arg 0; sender returns finish after 48 cycles; bitin=0x01 after 3 idle cycles → sendCmd=48'h400000000095, respR1=0x01, timeout=0, done held until req drops.
- CMD8, arg 0x1AA, respLong=1; MISO returns 0x01 then 0x000001AA → sendCmd=48'h48000001AA87, respR1=0x01, respData=0x000001AA.
- bitin held 1 after send, maxWait=64 → done with timeout=1 exactly 65 edges after WAIT entry; respR1=0.
- Start bit at exactly count 64 → accepted, no timeout.
- reset pulsed during SEND and during RECV → all outputs 0 asynchronously; the next request produces a correct frame.
- req dropped during CRC, then re-raised in DONE → first command completes with a one-cycle done pulse; no second command starts until req has been seen low.

Source files
------------

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types and constants for the SD SPI command path
//
// Purpose: state encoding for sd_cmd_sequencer, 48-bit command frame field
// offsets, the CRC7 polynomial with a single-bit update helper, and the SD
// command indices used by the top-level init sequence.
// Ports: none (package).
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRC,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_DONE
  } state_e;

  localparam int FRAME_W   = 48;
  localparam int START_BIT = 47;
  localparam int TX_BIT    = 46;
  localparam int IDX_MSB   = 45;
  localparam int IDX_LSB   = 40;
  localparam int ARG_MSB   = 39;
  localparam int ARG_LSB   = 8;
  localparam int CRC_MSB   = 7;
  localparam int CRC_LSB   = 1;
  localparam int END_BIT   = 0;

  // Frame bits 47..8 are covered by the CRC.
  localparam int CRC_BITS = 40;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD58  = 6'd58;

  // One MSB-first step of the CRC7 LFSR.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// rtl/crc7_serial.sv - bit-serial CRC7 generator, one bit per negedge
//
// Purpose: accumulates CRC7 (x^7+x^3+1, init 0) over a bit stream presented
// MSB first.
// Ports:
//   clk    - bit clock, state updates on negedge
//   rst    - asynchronous active-high reset
//   clear  - zero the CRC register (wins over enable)
//   enable - fold din into the CRC on this edge
//   din    - serial data bit
//   crc    - current CRC value
module crc7_serial
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = 7'h00;
    end else if (enable) begin
      crc_d = crc7_step(crc_q, din);
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - SD SPI command framing, send sequencing and response capture
//
// Purpose: latches a command index/argument, builds the 48-bit frame with a
// serially computed CRC7, drives the serial sender's start/finish handshake,
// hunts for the response start bit on MISO and shifts in R1 (plus an optional
// long payload), then reports with a four-phase req/done handshake.
// Ports:
//   spiClock   - bit clock; all state changes on its negedge
//   reset      - asynchronous active-high reset
//   req/done   - four-phase request/result handshake
//   cmdIndex, cmdArg, respLong - command inputs, sampled on the accepting edge
//   sendStart/sendCmd/sendFinish - handshake and frame to the serial sender
//   bitin      - MISO
//   busy       - accept until done
//   timeout, respR1, respData - result, valid with done
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int maxWait  = 64,
  parameter int longBits = 32
) (
  input  logic                spiClock,
  input  logic                reset,
  input  logic                req,
  input  logic [5:0]          cmdIndex,
  input  logic [31:0]         cmdArg,
  input  logic                respLong,
  output logic                sendStart,
  output logic [47:0]         sendCmd,
  input  logic                sendFinish,
  input  logic                bitin,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [7:0]          respR1,
  output logic [longBits-1:0] respData
);

  localparam int SR_W    = 8 + longBits;
  localparam int CNT_MAX = (maxWait > SR_W) ? maxWait : SR_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [5:0]            idx_q, idx_d;
  logic [31:0]           arg_q, arg_d;
  logic                  long_q, long_d;
  // Set once req has been sampled low since the last accept; a new command
  // needs it, so a req held high across DONE->IDLE cannot re-trigger.
  logic                  armed_q, armed_d;
  logic                  send_start_q, send_start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [7:0]            resp_r1_q, resp_r1_d;
  logic [longBits-1:0]   resp_data_q, resp_data_d;
  logic [SR_W-1:0]       sr_q, sr_d;

  logic [SR_W-1:0]       sr_shift;
  logic [CNT_W-1:0]      recv_last;
  logic [39:0]           payload;
  logic [5:0]            crc_sel;
  logic                  crc_clear;
  logic                  crc_en;
  logic [6:0]            crc_val;
  logic [FRAME_W-1:0]    frame;

  assign payload = {1'b0, 1'b1, idx_q, arg_q};
  assign crc_sel = 6'(CRC_BITS - 1) - cnt_q[5:0];

  crc7_serial u_crc (
    .clk    (spiClock),
    .rst    (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .din    (payload[crc_sel]),
    .crc    (crc_val)
  );

  always_comb begin
    frame                    = '0;
    frame[START_BIT]         = 1'b0;
    frame[TX_BIT]            = 1'b1;
    frame[IDX_MSB:IDX_LSB]   = idx_q;
    frame[ARG_MSB:ARG_LSB]   = arg_q;
    frame[CRC_MSB:CRC_LSB]   = crc_val;
    frame[END_BIT]           = 1'b1;
  end

  // The frame is only presented while the sender is being driven.
  assign sendCmd = (state_q == ST_SEND) ? frame : '0;

  // R1's MSB is consumed in WAIT, so RECV takes 7 more bits (+ payload).
  assign recv_last = long_q ? CNT_W'(SR_W - 2) : CNT_W'(6);
  assign sr_shift  = {sr_q[SR_W-2:0], bitin};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    arg_d        = arg_q;
    long_d       = long_q;
    armed_d      = armed_q | ~req;
    send_start_d = send_start_q;
    busy_d       = busy_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    resp_r1_d    = resp_r1_q;
    resp_data_d  = resp_data_q;
    sr_d         = sr_q;
    crc_clear    = 1'b0;
    crc_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req && armed_q) begin
          state_d   = ST_CRC;
          idx_d     = cmdIndex;
          arg_d     = cmdArg;
          long_d    = respLong;
          armed_d   = 1'b0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          crc_clear = 1'b1;
        end
      end

      ST_CRC: begin
        crc_en = 1'b1;
        if (cnt_q == CNT_W'(CRC_BITS - 1)) begin
          state_d      = ST_SEND;
          send_start_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SEND: begin
        if (sendFinish) begin
          state_d      = ST_WAIT;
          send_start_d = 1'b0;
          cnt_d        = '0;
        end
      end

      // cnt_q is the number of WAIT edges already spent, so this edge is
      // count cnt_q+1; a start bit up to count maxWait wins over timeout.
      ST_WAIT: begin
        if (!bitin && (cnt_q != CNT_W'(maxWait))) begin
          state_d = ST_RECV;
          cnt_d   = '0;
          sr_d    = '0;
        end else if (cnt_q == CNT_W'(maxWait)) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          timeout_d   = 1'b1;
          resp_r1_d   = 8'h00;
          resp_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RECV: begin
        sr_d = sr_shift;
        if (cnt_q == recv_last) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          timeout_d   = 1'b0;
          resp_r1_d   = long_q ? sr_shift[SR_W-1 -: 8] : sr_shift[7:0];
          resp_data_d = long_q ? sr_shift[longBits-1:0] : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        // armed_q means req already dropped during the operation.
        if (!req || armed_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
          armed_d = ~req;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(negedge spiClock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      arg_q        <= '0;
      long_q       <= 1'b0;
      armed_q      <= 1'b1;
      send_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      resp_r1_q    <= '0;
      resp_data_q  <= '0;
      sr_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      arg_q        <= arg_d;
      long_q       <= long_d;
      armed_q      <= armed_d;
      send_start_q <= send_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      resp_r1_q    <= resp_r1_d;
      resp_data_q  <= resp_data_d;
      sr_q         <= sr_d;
    end
  end

  assign sendStart = send_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign respR1    = resp_r1_q;
  assign respData  = resp_data_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb/tb_sd_cmd_sequencer.sv - self-checking bench for sd_cmd_sequencer
module tb_sd_cmd_sequencer;

  localparam int MAX_WAIT  = 64;
  localparam int LONG_BITS = 32;

  logic                 clk;
  logic                 reset;
  logic                 req;
  logic [5:0]           cmdIndex;
  logic [31:0]          cmdArg;
  logic                 respLong;
  logic                 sendStart;
  logic [47:0]          sendCmd;
  logic                 sendFinish;
  logic                 bitin;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic [7:0]           respR1;
  logic [LONG_BITS-1:0] respData;

  int errors = 0;
  int checks = 0;

  sd_cmd_sequencer #(.maxWait(MAX_WAIT), .longBits(LONG_BITS)) dut (
    .spiClock   (clk),
    .reset      (reset),
    .req        (req),
    .cmdIndex   (cmdIndex),
    .cmdArg     (cmdArg),
    .respLong   (respLong),
    .sendStart  (sendStart),
    .sendCmd    (sendCmd),
    .sendFinish (sendFinish),
    .bitin      (bitin),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .respR1     (respR1),
    .respData   (respData)
  );

  always #5 clk = ~clk;

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    msg = {2'b01, idx, arg};
    return {msg, ref_crc7(msg), 1'b1};
  endfunction

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (sendStart !== 1'b0 || sendCmd !== 48'h0 || busy !== 1'b0 || done !== 1'b0 ||
        timeout !== 1'b0 || respR1 !== 8'h0 || respData !== '0) begin
      errors++;
      $display("FAIL %s: start=%b cmd=%h busy=%b done=%b to=%b r1=%h data=%h, required all zero",
               tag, sendStart, sendCmd, busy, done, timeout, respR1, respData);
    end
    req = 1'b0;
    sendFinish = 1'b0;
    bitin = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // One full transaction: request, sender handshake, MISO response, release.
  // abort: 0 none, 1 reset while sending, 2 reset while receiving.
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic lng, input logic [47:0] exp_frame, input int fin_dly,
                         input int idle, input logic [7:0] r1, input logic [31:0] dat,
                         input int exp_done_j, input int abort);
    int k, j, fed, nbits, hold;
    bit got, resp_ok;
    logic [39:0] resp;
    logic [7:0] exp_r1;
    logic [31:0] exp_dat;

    resp_ok = (idle + 1 <= MAX_WAIT);
    exp_r1  = resp_ok ? r1 : 8'h00;
    exp_dat = (resp_ok && lng) ? dat : 32'h0;
    nbits   = lng ? 40 : 8;
    resp    = {r1, dat};

    @(posedge clk);
    req = 1'b1; cmdIndex = idx; cmdArg = arg; respLong = lng;
    k = 0;
    while (!sendStart && k < 100) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (k != 41) begin
      errors++;
      $display("FAIL %s accept_to_start: got %0d edges, required 41", tag, k);
    end
    checks++;
    if (sendCmd !== exp_frame) begin
      errors++;
      $display("FAIL %s frame: got %h, required %h", tag, sendCmd, exp_frame);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_during: got %b, required 1", tag, busy);
    end
    cmdIndex = 6'($urandom); cmdArg = $urandom; respLong = 1'($urandom);
    if (abort == 1) begin
      apply_reset({tag, "_reset_send"});
      return;
    end
    repeat (fin_dly) @(posedge clk);
    checks++;
    if (sendStart !== 1'b1 || sendCmd !== exp_frame) begin
      errors++;
      $display("FAIL %s frame_hold: start=%b cmd=%h, required 1 and %h", tag, sendStart, sendCmd, exp_frame);
    end
    sendFinish = 1'b1;
    @(posedge clk);
    sendFinish = 1'b0;
    checks++;
    if (sendStart !== 1'b0) begin
      errors++;
      $display("FAIL %s start_drop: got %b, required 0", tag, sendStart);
    end

    j = 0; fed = 0; got = 0;
    while (!got && j < 400) begin
      if (j < idle || fed >= nbits) begin
        bitin = 1'b1;
      end else begin
        bitin = resp[39];
        resp = resp << 1;
        fed++;
      end
      @(posedge clk);
      j++;
      if (abort == 2 && fed == 3) begin
        apply_reset({tag, "_reset_recv"});
        return;
      end
      if (done) got = 1;
    end
    bitin = 1'b1;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_wait: done not seen in %0d edges, required done", tag, j);
    end else begin
      if (exp_done_j >= 0) begin
        checks++;
        if (j != exp_done_j) begin
          errors++;
          $display("FAIL %s done_latency: got %0d edges, required %0d", tag, j, exp_done_j);
        end
      end
      checks++;
      if (timeout !== !resp_ok || respR1 !== exp_r1 || respData !== exp_dat || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s result: to=%b r1=%h data=%h busy=%b, required to=%b r1=%h data=%h busy=0",
                 tag, timeout, respR1, respData, busy, !resp_ok, exp_r1, exp_dat);
      end
      hold = $urandom_range(1, 4);
      repeat (hold) @(posedge clk);
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL %s done_hold: got %b, required 1", tag, done);
      end
    end
    req = 1'b0;
    @(posedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_release: got %b, required 0", tag, done);
    end
  endtask

  task automatic test_reset;
    apply_reset("reset");
  endtask

  task automatic test_cmd0;
    run_cmd("cmd0", 6'd0, 32'h0, 1'b0, 48'h400000000095, 48, 3, 8'h01, 32'h0, -1, 0);
  endtask

  task automatic test_cmd8;
    run_cmd("cmd8", 6'd8, 32'h1AA, 1'b1, 48'h48000001AA87, 48, 2, 8'h01, 32'h000001AA, -1, 0);
  endtask

  task automatic test_timeout;
    run_cmd("timeout", 6'd58, 32'h0, 1'b0, ref_frame(6'd58, 32'h0), 5, 200, 8'h00, 32'h0, MAX_WAIT + 1, 0);
  endtask

  task automatic test_start_at_limit;
    run_cmd("limit", 6'd55, 32'h0, 1'b0, ref_frame(6'd55, 32'h0), 7, MAX_WAIT - 1, 8'h05, 32'h0, -1, 0);
  endtask

  task automatic test_reset_mid;
    logic [31:0] a;
    a = $urandom;
    run_cmd("rst_send", 6'd41, a, 1'b0, ref_frame(6'd41, a), 0, 0, 8'h00, 32'h0, -1, 1);
    run_cmd("rst_recv", 6'd8, a, 1'b1, ref_frame(6'd8, a), 3, 4, 8'h01, a, -1, 2);
    a = 32'h40300000;
    run_cmd("after_rst", 6'd41, a, 1'b0, ref_frame(6'd41, a), 10, 5, 8'h00, 32'h0, -1, 0);
  endtask

  task automatic test_req_drop;
    int k, j;
    bit got, stray;
    logic [7:0] r;
    @(posedge clk);
    req = 1'b1; cmdIndex = 6'd55; cmdArg = 32'h0; respLong = 1'b0;
    k = 0;
    while (!sendStart && k < 100) begin
      @(posedge clk);
      k++;
      if (k == 5) req = 1'b0;
    end
    checks++;
    if (k != 41 || sendCmd !== ref_frame(6'd55, 32'h0)) begin
      errors++;
      $display("FAIL drop_start: %0d edges cmd=%h, required 41 and %h", k, sendCmd, ref_frame(6'd55, 32'h0));
    end
    sendFinish = 1'b1;
    @(posedge clk);
    sendFinish = 1'b0;
    r = 8'h01;
    j = 0; got = 0;
    while (!got && j < 100) begin
      if (j < 1 || j > 8) begin
        bitin = 1'b1;
      end else begin
        bitin = r[7];
        r = r << 1;
      end
      @(posedge clk);
      j++;
      if (done) got = 1;
    end
    bitin = 1'b1;
    checks++;
    if (!got || respR1 !== 8'h01 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL drop_result: done=%b r1=%h to=%b, required 1 01 0", got, respR1, timeout);
    end
    req = 1'b1;
    @(posedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse: done=%b one edge later, required 0", done);
    end
    stray = 0;
    repeat (50) begin
      @(posedge clk);
      if (busy !== 1'b0 || sendStart !== 1'b0) stray = 1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL drop_no_restart: busy/start rose with req held, required none");
    end
    req = 1'b0;
    @(posedge clk);
    req = 1'b1;
    k = 0;
    while (!sendStart && k < 100) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (k != 41) begin
      errors++;
      $display("FAIL drop_rearm: got %0d edges to start, required 41", k);
    end
    apply_reset("drop_cleanup");
  endtask

  task automatic test_back_to_back;
    logic [5:0] idx;
    logic [31:0] arg, dat;
    logic lng;
    logic [7:0] r1;
    for (int n = 0; n < 8; n++) begin
      idx = 6'($urandom_range(0, 63));
      arg = $urandom;
      dat = $urandom;
      lng = 1'($urandom_range(0, 1));
      r1  = {1'b0, 7'($urandom)};
      run_cmd("b2b", idx, arg, lng, ref_frame(idx, arg), $urandom_range(0, 60),
              $urandom_range(0, 80), r1, dat, -1, 0);
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; req = 1'b0; cmdIndex = '0; cmdArg = '0;
    respLong = 1'b0; sendFinish = 1'b0; bitin = 1'b1;
    test_reset();
    test_cmd0();
    test_cmd8();
    test_timeout();
    test_start_at_limit();
    test_reset_mid();
    test_req_drop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
